alu_control_sequencer: RTL and testbench
========================================

# alu_control_sequencer

Moore control unit that drives the Mini SRC datapath's bus-select, register-enable, memory and ALU-select strobes through instruction fetch and execute. Each instruction runs as a sequence of one-cycle control steps. The block sits beside `datapath`: its outputs connect to the datapath control inputs, the datapath's `IR_Data` connects back as `ir`, and `mem_ready` comes from the memory interface. It replaces hand-driven control sequences for register-register ALU, mul/div, neg/not, nop and halt.

## Interface
- `IR_W`, default 32: instruction register width.
- `OP_W`, default 5: opcode width, taken from `ir[31:27]`.
- `clk`, in, 1: single clock; every state change happens on the rising edge.
- `clr`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `run`, in, 1: start/continue request. Only a rising edge is acted on while halted.
- `mem_ready`, in, 1: memory read data valid on `Mdatain`.
- `ir`, in, IR_W: current IR contents (`IR_Data`).
- `PC_out`, `MAR_in`, `Z_in`, `IncPC`, `Zlow_out`, `Zhigh_out`, `PC_in`, `Read`, `MDR_in`, `MDR_out`, `IR_in`, `Y_in`, `LO_in`, `HI_in`, out, 1 each: datapath strobes.
- `Gra`, `Grb`, `Grc`, `R_in`, `R_out`, out, 1 each: register-field selects for the external select/encode logic (Ra=`ir[26:23]`, Rb=`ir[22:19]`, Rc=`ir[18:15]`).
- `alu_instruction`, out, OP_W: ALU operation select. Equals `ir[31:27]` in execute Z_in states and 0 otherwise.
- `busy`, out, 1: high in every state except HALT.
- `illegal`, out, 1: sticky flag for an unsupported opcode.
- `done`, out, 1: one-cycle pulse in the final step of each instruction.

## Operation
- States: HALT, T0, T1, T2, T3, T4, T5, T6. Use a 3-bit or one-hot encoding.
- Outputs are combinational from the registered state and `ir` only. There are no glitch paths from `run` or `mem_ready`, except the T1 `MDR_in` qualifier.
- Fetch:
  - T0: PC_out, MAR_in, IncPC, Z_in.
  - T1: Zlow_out and PC_in are asserted only in the first T1 cycle. Read is held for every T1 cycle. MDR_in = `mem_ready`. Stay in T1 while `mem_ready`=0.
  - T2: MDR_out, IR_in.
- Execute, decoded from `ir[31:27]` in T3 onward:
  - 3-register ALU ops, 00011–01011 (add, sub, and, or, shr, shra, shl, ror, rol): T3 Grb+R_out+Y_in; T4 Grc+R_out+Z_in+alu_instruction; T5 Zlow_out+Gra+R_in+done.
  - mul 01111 / div 10000: T3 Gra+R_out+Y_in; T4 Grb+R_out+Z_in+alu_instruction; T5 Zlow_out+LO_in; T6 Zhigh_out+HI_in+done.
  - neg 10001 / not 10010: T3 Grb+R_out+Z_in+alu_instruction; T4 Zlow_out+Gra+R_in+done.
  - nop 11010: done in T3, no strobes.
  - halt 11011: done in T3, then go to HALT.
  - Any other opcode: set `illegal`, assert done in T3, then go to HALT.
- After the done step: go to T0 if `run`=1, otherwise HALT. A `run` deassertion mid-instruction never truncates the instruction.
- HALT: all strobes 0. Go to T0 on a `run` rising edge, detected with a registered `run_q`. `illegal` is cleared on that transition.
- Reset (`clr`=0 at an edge, in any state including T1 wait or mid-execute):
  - Next state is HALT.
  - `illegal`=0, `run_q`=0.
  - All outputs are 0 in the following cycle.
  - Reset takes priority over every other transition.

## Timing
- Each state lasts exactly 1 cycle, except T1, which lasts 1 + (number of cycles with `mem_ready`=0).
- Cycles per instruction with zero-wait memory: nop/halt 4, neg/not 5, ALU 6, mul/div 7.
- The datapath captures on the edge that ends each state. `ir` is valid from T3 because IR latches at the end of T2.
- `run` rising edge at edge k in HALT: T0 is active in cycle k+1.
- `done` and the next T0 are never in the same cycle.
- A `mem_ready` pulse that arrives in T0 is ignored; only T1 samples it.

## Test plan
- Reset: hold `clr`=0 for 2 edges in any state. Required: all strobes 0, `busy`=0, `illegal`=0, `alu_instruction`=0.
- shra: R3=0x8000FA92, R5=0xA, `ir`=0x409A8000, `mem_ready`=1, one `run` pulse. Required: T3 Grb/R_out/Y_in; T4 Grc/R_out/Z_in with alu_instruction=01000; T5 Gra/R_in/Zlow_out/done. R1 ends at 0xFFE0003E. The instruction takes 6 cycles, then HALT.
- Memory wait: hold `mem_ready`=0 for 3 cycles in T1. Required: T1 lasts 4 cycles with Read high throughout; PC_in only in the first T1 cycle; MDR_in only in the 4th.
- mul R3,R5 with R3=0x10000, R5=0x10000. Required: LO_in in T5 and HI_in in T6; LO=0, HI=0x1; done in T6.
- Halt and illegal: opcode 11011 gives done in T3, then `busy`=0 with `illegal`=0. Opcode 11111 gives `illegal`=1 until the next `run` rising edge.
- `run` held high: back-to-back add then neg. Required: T0 follows the done step immediately; the total is 11 cycles.
- Reset mid-instruction: `clr`=0 at the T4 edge of the add. Required: the next cycle is HALT with Z_in=0 and R_in=0; Ra is never written.

Source files
------------

// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the Mini SRC control sequencer and its datapath.
// The slave side is the sequencer; the master side is the datapath/memory
// environment that supplies run, mem_ready and the IR contents.
interface alu_control_sequencer_if #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
);
  logic            run;
  logic            mem_ready;
  logic [IR_W-1:0] ir;

  logic            PC_out;
  logic            MAR_in;
  logic            Z_in;
  logic            IncPC;
  logic            Zlow_out;
  logic            Zhigh_out;
  logic            PC_in;
  logic            Read;
  logic            MDR_in;
  logic            MDR_out;
  logic            IR_in;
  logic            Y_in;
  logic            LO_in;
  logic            HI_in;

  logic            Gra;
  logic            Grb;
  logic            Grc;
  logic            R_in;
  logic            R_out;

  logic [OP_W-1:0] alu_instruction;
  logic            busy;
  logic            illegal;
  logic            done;

  modport master (
    output run, mem_ready, ir,
    input  PC_out, MAR_in, Z_in, IncPC, Zlow_out, Zhigh_out, PC_in, Read,
           MDR_in, MDR_out, IR_in, Y_in, LO_in, HI_in,
           Gra, Grb, Grc, R_in, R_out,
           alu_instruction, busy, illegal, done
  );

  modport slave (
    input  run, mem_ready, ir,
    output PC_out, MAR_in, Z_in, IncPC, Zlow_out, Zhigh_out, PC_in, Read,
           MDR_in, MDR_out, IR_in, Y_in, LO_in, HI_in,
           Gra, Grb, Grc, R_in, R_out,
           alu_instruction, busy, illegal, done
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// Moore control sequencer for the Mini SRC datapath. Walks each instruction
// through fetch (T0..T2) and a class-dependent execute sequence (T3..T6),
// emitting one set of datapath strobes per step. Strobes depend only on the
// registered state and the IR, apart from MDR_in which follows mem_ready in T1.
module alu_control_sequencer #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input logic                  clk,
  input logic                  clr,
  alu_control_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_UNARY   = 3'd2,
    CLS_NOP     = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  state_t          state_r;
  state_t          next_state_s;
  state_t          finish_state_s;
  op_class_t       cls_s;
  logic [OP_W-1:0] op_s;
  logic            run_q;
  logic            run_rise_s;
  logic            t1_wait_r;
  logic            illegal_r;
  logic            illegal_set_s;
  logic            halt_exit_s;

  assign op_s          = bus.ir[IR_W-1 -: OP_W];
  assign run_rise_s    = bus.run & ~run_q;
  assign illegal_set_s = (state_r == S_T3) && (cls_s == CLS_ILLEGAL);
  assign halt_exit_s   = (state_r == S_HALT) && run_rise_s;
  assign bus.illegal   = illegal_r;

  // Sort the opcode into the execute sequence it needs.
  always_comb begin
    cls_s = CLS_ILLEGAL;
    if ((op_s >= OP_W'(5'd3)) && (op_s <= OP_W'(5'd11))) begin
      cls_s = CLS_ALU;
    end else if ((op_s == OP_W'(5'd15)) || (op_s == OP_W'(5'd16))) begin
      cls_s = CLS_MULDIV;
    end else if ((op_s == OP_W'(5'd17)) || (op_s == OP_W'(5'd18))) begin
      cls_s = CLS_UNARY;
    end else if (op_s == OP_W'(5'd26)) begin
      cls_s = CLS_NOP;
    end else if (op_s == OP_W'(5'd27)) begin
      cls_s = CLS_HALT;
    end else begin
      cls_s = CLS_ILLEGAL;
    end
  end

  // State register plus run edge history, T1 wait marker and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r   <= S_HALT;
      run_q     <= 1'b0;
      t1_wait_r <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      run_q     <= bus.run;
      // Marks that the next T1 cycle is a repeat, so PC update strobes stay off.
      t1_wait_r <= (state_r == S_T1) && !bus.mem_ready;
      if (illegal_set_s) begin
        illegal_r <= 1'b1;
      end else if (halt_exit_s) begin
        illegal_r <= 1'b0;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  // Next-state and strobe decode for the current control step.
  always_comb begin
    next_state_s        = S_HALT;
    finish_state_s      = bus.run ? S_T0 : S_HALT;
    bus.PC_out          = 1'b0;
    bus.MAR_in          = 1'b0;
    bus.Z_in            = 1'b0;
    bus.IncPC           = 1'b0;
    bus.Zlow_out        = 1'b0;
    bus.Zhigh_out       = 1'b0;
    bus.PC_in           = 1'b0;
    bus.Read            = 1'b0;
    bus.MDR_in          = 1'b0;
    bus.MDR_out         = 1'b0;
    bus.IR_in           = 1'b0;
    bus.Y_in            = 1'b0;
    bus.LO_in           = 1'b0;
    bus.HI_in           = 1'b0;
    bus.Gra             = 1'b0;
    bus.Grb             = 1'b0;
    bus.Grc             = 1'b0;
    bus.R_in            = 1'b0;
    bus.R_out           = 1'b0;
    bus.alu_instruction = {OP_W{1'b0}};
    bus.done            = 1'b0;
    bus.busy            = (state_r != S_HALT);

    case (state_r)
      S_HALT: begin
        if (run_rise_s) begin
          next_state_s = S_T0;
        end else begin
          next_state_s = S_HALT;
        end
      end
      S_T0: begin
        bus.PC_out   = 1'b1;
        bus.MAR_in   = 1'b1;
        bus.IncPC    = 1'b1;
        bus.Z_in     = 1'b1;
        next_state_s = S_T1;
      end
      S_T1: begin
        bus.Read     = 1'b1;
        bus.Zlow_out = ~t1_wait_r;
        bus.PC_in    = ~t1_wait_r;
        bus.MDR_in   = bus.mem_ready;
        if (bus.mem_ready) begin
          next_state_s = S_T2;
        end else begin
          next_state_s = S_T1;
        end
      end
      S_T2: begin
        bus.MDR_out  = 1'b1;
        bus.IR_in    = 1'b1;
        next_state_s = S_T3;
      end
      S_T3: begin
        case (cls_s)
          CLS_ALU: begin
            bus.Grb      = 1'b1;
            bus.R_out    = 1'b1;
            bus.Y_in     = 1'b1;
            next_state_s = S_T4;
          end
          CLS_MULDIV: begin
            bus.Gra      = 1'b1;
            bus.R_out    = 1'b1;
            bus.Y_in     = 1'b1;
            next_state_s = S_T4;
          end
          CLS_UNARY: begin
            bus.Grb             = 1'b1;
            bus.R_out           = 1'b1;
            bus.Z_in            = 1'b1;
            bus.alu_instruction = op_s;
            next_state_s        = S_T4;
          end
          CLS_NOP: begin
            bus.done     = 1'b1;
            next_state_s = finish_state_s;
          end
          CLS_HALT: begin
            bus.done     = 1'b1;
            next_state_s = S_HALT;
          end
          default: begin
            bus.done     = 1'b1;
            next_state_s = S_HALT;
          end
        endcase
      end
      S_T4: begin
        case (cls_s)
          CLS_ALU: begin
            bus.Grc             = 1'b1;
            bus.R_out           = 1'b1;
            bus.Z_in            = 1'b1;
            bus.alu_instruction = op_s;
            next_state_s        = S_T5;
          end
          CLS_MULDIV: begin
            bus.Grb             = 1'b1;
            bus.R_out           = 1'b1;
            bus.Z_in            = 1'b1;
            bus.alu_instruction = op_s;
            next_state_s        = S_T5;
          end
          CLS_UNARY: begin
            bus.Zlow_out = 1'b1;
            bus.Gra      = 1'b1;
            bus.R_in     = 1'b1;
            bus.done     = 1'b1;
            next_state_s = finish_state_s;
          end
          default: begin
            next_state_s = S_HALT;
          end
        endcase
      end
      S_T5: begin
        case (cls_s)
          CLS_ALU: begin
            bus.Zlow_out = 1'b1;
            bus.Gra      = 1'b1;
            bus.R_in     = 1'b1;
            bus.done     = 1'b1;
            next_state_s = finish_state_s;
          end
          CLS_MULDIV: begin
            bus.Zlow_out = 1'b1;
            bus.LO_in    = 1'b1;
            next_state_s = S_T6;
          end
          default: begin
            next_state_s = S_HALT;
          end
        endcase
      end
      S_T6: begin
        bus.Zhigh_out = 1'b1;
        bus.HI_in     = 1'b1;
        bus.done      = 1'b1;
        next_state_s  = finish_state_s;
      end
      default: begin
        next_state_s = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: builds the expected strobe word for every
// cycle from the instruction class, memory wait count and run behaviour.
module tb_alu_control_sequencer;
  localparam int IR_W = 32;
  localparam int OP_W = 5;

  localparam int B_PC_OUT  = 0;
  localparam int B_MAR_IN  = 1;
  localparam int B_Z_IN    = 2;
  localparam int B_INC_PC  = 3;
  localparam int B_ZLOW    = 4;
  localparam int B_ZHIGH   = 5;
  localparam int B_PC_IN   = 6;
  localparam int B_READ    = 7;
  localparam int B_MDR_IN  = 8;
  localparam int B_MDR_OUT = 9;
  localparam int B_IR_IN   = 10;
  localparam int B_Y_IN    = 11;
  localparam int B_LO_IN   = 12;
  localparam int B_HI_IN   = 13;
  localparam int B_GRA     = 14;
  localparam int B_GRB     = 15;
  localparam int B_GRC     = 16;
  localparam int B_R_IN    = 17;
  localparam int B_R_OUT   = 18;
  localparam int B_DONE    = 19;
  localparam int B_BUSY    = 20;
  localparam int B_ILL     = 21;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  alu_control_sequencer_if #(.IR_W(IR_W), .OP_W(OP_W)) ifc ();

  alu_control_sequencer #(.IR_W(IR_W), .OP_W(OP_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  logic [26:0] obs;
  assign obs = {ifc.alu_instruction, ifc.illegal, ifc.busy, ifc.done,
                ifc.R_out, ifc.R_in, ifc.Grc, ifc.Grb, ifc.Gra,
                ifc.HI_in, ifc.LO_in, ifc.Y_in, ifc.IR_in, ifc.MDR_out,
                ifc.MDR_in, ifc.Read, ifc.PC_in, ifc.Zhigh_out, ifc.Zlow_out,
                ifc.IncPC, ifc.Z_in, ifc.MAR_in, ifc.PC_out};

  int   n_tests   = 0;
  int   n_fail    = 0;
  int   busy_seen = 0;
  logic illegal_m = 1'b0;
  logic to_t0;

  // 0 alu, 1 mul/div, 2 neg/not, 3 nop, 4 halt, 5 unsupported
  function automatic int op_class(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return 0;
    if (op == 5'd15 || op == 5'd16) return 1;
    if (op == 5'd17 || op == 5'd18) return 2;
    if (op == 5'd26) return 3;
    if (op == 5'd27) return 4;
    return 5;
  endfunction

  function automatic int exec_len(input int cls);
    case (cls)
      0:       return 3;
      1:       return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [26:0] halt_word(input logic ill);
    logic [26:0] v;
    v = 27'd0;
    v[B_ILL] = ill;
    return v;
  endfunction

  // Expected strobes for cycle c of an instruction (c=0 is T0) with w memory waits.
  function automatic logic [26:0] exp_word(input logic [4:0] op, input int c, input int w);
    logic [26:0] v;
    int e;
    int cls;
    v = 27'd0;
    v[B_BUSY] = 1'b1;
    cls = op_class(op);
    if (c == 0) begin
      v[B_PC_OUT] = 1'b1; v[B_MAR_IN] = 1'b1; v[B_INC_PC] = 1'b1; v[B_Z_IN] = 1'b1;
    end else if (c <= w + 1) begin
      v[B_READ] = 1'b1;
      if (c == 1) begin v[B_ZLOW] = 1'b1; v[B_PC_IN] = 1'b1; end
      if (c == w + 1) v[B_MDR_IN] = 1'b1;
    end else if (c == w + 2) begin
      v[B_MDR_OUT] = 1'b1; v[B_IR_IN] = 1'b1;
    end else begin
      e = c - (w + 3);
      case (cls)
        0: case (e)
             0: begin v[B_GRB] = 1'b1; v[B_R_OUT] = 1'b1; v[B_Y_IN] = 1'b1; end
             1: begin v[B_GRC] = 1'b1; v[B_R_OUT] = 1'b1; v[B_Z_IN] = 1'b1; v[26:22] = op; end
             default: begin v[B_ZLOW] = 1'b1; v[B_GRA] = 1'b1; v[B_R_IN] = 1'b1; v[B_DONE] = 1'b1; end
           endcase
        1: case (e)
             0: begin v[B_GRA] = 1'b1; v[B_R_OUT] = 1'b1; v[B_Y_IN] = 1'b1; end
             1: begin v[B_GRB] = 1'b1; v[B_R_OUT] = 1'b1; v[B_Z_IN] = 1'b1; v[26:22] = op; end
             2: begin v[B_ZLOW] = 1'b1; v[B_LO_IN] = 1'b1; end
             default: begin v[B_ZHIGH] = 1'b1; v[B_HI_IN] = 1'b1; v[B_DONE] = 1'b1; end
           endcase
        2: case (e)
             0: begin v[B_GRB] = 1'b1; v[B_R_OUT] = 1'b1; v[B_Z_IN] = 1'b1; v[26:22] = op; end
             default: begin v[B_ZLOW] = 1'b1; v[B_GRA] = 1'b1; v[B_R_IN] = 1'b1; v[B_DONE] = 1'b1; end
           endcase
        default: v[B_DONE] = 1'b1;
      endcase
    end
    return v;
  endfunction

  task automatic step(input logic run_v, input logic mr_v, input logic [IR_W-1:0] ir_v,
                      input logic [26:0] exp, input string tag, input int c);
    ifc.run       = run_v;
    ifc.mem_ready = mr_v;
    ifc.ir        = ir_v;
    @(negedge clk);
    n_tests++;
    if (obs[B_BUSY]) busy_seen++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic halt_cycle(input logic run_v, input string tag);
    step(run_v, 1'($urandom_range(0, 1)), 32'($urandom), halt_word(illegal_m), tag, -1);
  endtask

  task automatic start_from_halt(input string tag);
    halt_cycle(1'b0, tag);
    halt_cycle(1'b1, tag);
    illegal_m = 1'b0;
  endtask

  // Runs one instruction from its T0; abort_at >= 0 applies clr at that cycle.
  task automatic do_instr(input logic [IR_W-1:0] ir_word, input int w, input logic hold,
                          input int abort_at, input string tag, output logic next_t0);
    logic [4:0] op;
    int cls;
    int len;
    logic mr;
    logic rv;
    logic [IR_W-1:0] irv;
    op  = ir_word[31:27];
    cls = op_class(op);
    len = w + 3 + exec_len(cls);
    for (int c = 0; c < len; c++) begin
      if (c == 0) mr = 1'b1;
      else if (c <= w) mr = 1'b0;
      else if (c == w + 1) mr = 1'b1;
      else mr = 1'($urandom_range(0, 1));
      irv = (c >= w + 3) ? ir_word : 32'($urandom);
      rv  = (c == len - 1) ? hold : 1'($urandom_range(0, 1));
      if (c == abort_at) clr = 1'b0;
      step(rv, mr, irv, exp_word(op, c, w), tag, c);
      if (c == abort_at) begin
        step(1'b0, 1'b1, irv, halt_word(1'b0), {tag, "_after_clr"}, c + 1);
        clr       = 1'b1;
        illegal_m = 1'b0;
        next_t0   = 1'b0;
        return;
      end
    end
    if (cls == 5) illegal_m = 1'b1;
    next_t0 = hold && (cls <= 3);
  endtask

  initial begin
    clr           = 1'b0;
    ifc.run       = 1'b0;
    ifc.mem_ready = 1'b0;
    ifc.ir        = 32'd0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 32'h409A8000, halt_word(1'b0), "reset_1", 0);
    step(1'b0, 1'b1, 32'h409A8000, halt_word(1'b0), "reset_2", 1);
    clr = 1'b1;

    // shra R1,R3,R5 with zero-wait memory, single run pulse
    start_from_halt("shra");
    do_instr(32'h409A8000, 0, 1'b0, -1, "shra", to_t0);
    halt_cycle(1'b0, "shra_halt");

    // three wait cycles in T1
    start_from_halt("memwait");
    do_instr({5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 3, 1'b0, -1, "memwait", to_t0);

    // mul R3,R5
    start_from_halt("mul");
    do_instr({5'd15, 4'd3, 4'd5, 19'd0}, 0, 1'b0, -1, "mul", to_t0);

    // halt stops even with run held high
    start_from_halt("halt");
    do_instr({5'd27, 27'd0}, 0, 1'b1, -1, "halt", to_t0);
    halt_cycle(1'b1, "halt_stay");
    halt_cycle(1'b0, "halt_stay");

    // unsupported opcode: sticky illegal until the next run rising edge
    start_from_halt("illegal");
    do_instr({5'd31, 27'd0}, 1, 1'b1, -1, "illegal", to_t0);
    halt_cycle(1'b1, "illegal_sticky");
    halt_cycle(1'b1, "illegal_sticky");
    halt_cycle(1'b1, "illegal_sticky");
    start_from_halt("illegal_clear");
    do_instr({5'd26, 27'd0}, 0, 1'b0, -1, "nop_after_illegal", to_t0);

    // back-to-back add then neg with run held high
    start_from_halt("b2b");
    busy_seen = 0;
    do_instr({5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b1, -1, "b2b_add", to_t0);
    do_instr({5'd17, 4'd4, 4'd5, 19'd0}, 0, 1'b0, -1, "b2b_neg", to_t0);
    n_tests++;
    assert (busy_seen == 11) else begin
      n_fail++;
      $error("FAIL b2b_cycles observed=%0d expected=%0d", busy_seen, 11);
    end

    // reset at the T4 edge of an add
    start_from_halt("rst_mid");
    do_instr({5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1'b0, 5, "rst_mid", to_t0);
    halt_cycle(1'b0, "rst_mid_halt");

    // randomized instruction stream
    to_t0 = 1'b0;
    repeat (40) begin
      if (!to_t0) start_from_halt("rand");
      do_instr(32'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, "rand", to_t0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
